// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 pins, deserialises
// 11-bit frames and folds E0/F0 prefixes into one make/break event per key.
module ps2_scan_receiver #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2Clk,
    input  logic        ps2Dat,
    output logic [15:0] ps2Data,
    output logic        ps2Valid,
    output logic        ps2Break,
    output logic [7:0]  rawByte,
    output logic        rawValid,
    output logic        frameErr
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state, state_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shift, shift_nx;
    logic          par, par_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic          ext, ext_nx;
    logic          brk, brk_nx;
    logic [15:0]   data_nx;
    logic          break_nx;
    logic [7:0]    raw_nx;
    logic          raw_valid_nx, ps2_valid_nx, err_nx;
    logic          frame_ok;

    // Idle-high reset values keep a freshly released bus from looking like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value of its source.
            clk_s1 <= ps2Clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2Dat;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered level flips only on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                    fall     <= filt_clk;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign frame_ok = dat_s2 & (^{shift, par});

    always_comb begin
        // NOTE: every comb output gets a default up front so no path can infer a latch.
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        shift_nx     = shift;
        par_nx       = par;
        tmo_nx       = tmo;
        ext_nx       = ext;
        brk_nx       = brk;
        data_nx      = ps2Data;
        break_nx     = ps2Break;
        raw_nx       = rawByte;
        raw_valid_nx = 1'b0;
        ps2_valid_nx = 1'b0;
        err_nx       = 1'b0;

        case (state)
            ST_IDLE: begin
                tmo_nx = '0;
                if (fall && !dat_s2) begin
                    state_nx   = ST_FRAME;
                    bit_cnt_nx = 4'd1;
                end
            end
            ST_FRAME: begin
                if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                    // Timeout closes the old frame; a coincident edge may open a new one.
                    err_nx = 1'b1;
                    ext_nx = 1'b0;
                    brk_nx = 1'b0;
                    tmo_nx = '0;
                    if (fall && !dat_s2) begin
                        bit_cnt_nx = 4'd1;
                    end else begin
                        state_nx   = ST_IDLE;
                        bit_cnt_nx = 4'd0;
                    end
                end else if (fall) begin
                    tmo_nx = '0;
                    if (bit_cnt == 4'd10) begin
                        state_nx   = ST_IDLE;
                        bit_cnt_nx = 4'd0;
                        if (frame_ok) begin
                            raw_nx       = shift;
                            raw_valid_nx = 1'b1;
                            case (shift)
                                8'hE0: ext_nx = 1'b1;
                                8'hF0: brk_nx = 1'b1;
                                default: begin
                                    data_nx      = {(ext ? 8'hE0 : 8'h00), shift};
                                    break_nx     = brk;
                                    ps2_valid_nx = 1'b1;
                                    ext_nx       = 1'b0;
                                    brk_nx       = 1'b0;
                                end
                            endcase
                        end else begin
                            err_nx = 1'b1;
                            ext_nx = 1'b0;
                            brk_nx = 1'b0;
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) begin
                            par_nx = dat_s2;
                        end else begin
                            shift_nx = {dat_s2, shift[7:1]};
                        end
                    end
                end else begin
                    tmo_nx = tmo + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            par      <= 1'b0;
            tmo      <= '0;
            ext      <= 1'b0;
            brk      <= 1'b0;
            ps2Data  <= 16'h0000;
            ps2Break <= 1'b0;
            rawByte  <= 8'h00;
            rawValid <= 1'b0;
            ps2Valid <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_cnt_nx;
            shift    <= shift_nx;
            par      <= par_nx;
            tmo      <= tmo_nx;
            ext      <= ext_nx;
            brk      <= brk_nx;
            ps2Data  <= data_nx;
            ps2Break <= break_nx;
            rawByte  <= raw_nx;
            rawValid <= raw_valid_nx;
            ps2Valid <= ps2_valid_nx;
            frameErr <= err_nx;
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: drives PS/2 frames on the pins, predicts events with a
// key-level model and checks them in a monitor that pops a scoreboard on each strobe.
module tb_ps2_scan_receiver;

    localparam int HALF = 20;

    typedef struct {
        logic [15:0] data;
        logic        brk;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2Clk = 1'b1;
    logic        ps2Dat = 1'b1;
    logic [15:0] ps2Data;
    logic        ps2Valid;
    logic        ps2Break;
    logic [7:0]  rawByte;
    logic        rawValid;
    logic        frameErr;

    int   checks = 0;
    int   errors = 0;
    int   exp_err = 0;
    int   err_seen = 0;
    logic [7:0] raw_q[$];
    evt_t       evt_q[$];
    bit          m_ext = 1'b0;
    bit          m_brk = 1'b0;
    logic [15:0] m_data = 16'h0000;
    logic        m_break = 1'b0;
    logic [7:0]  mon_b;
    evt_t        mon_e;

    ps2_scan_receiver #(.FILTER_LEN(4), .TIMEOUT_CYC(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2Clk   (ps2Clk),
        .ps2Dat   (ps2Dat),
        .ps2Data  (ps2Data),
        .ps2Valid (ps2Valid),
        .ps2Break (ps2Break),
        .rawByte  (rawByte),
        .rawValid (rawValid),
        .frameErr (frameErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Key-level reference: prefixes only modify the pending flags, any other good byte is an event.
    function automatic void model_frame(input logic [7:0] b, input bit good);
        evt_t ev;
        if (!good) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            raw_q.push_back(b);
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                ev.data = {(m_ext ? 8'hE0 : 8'h00), b};
                ev.brk  = m_brk;
                evt_q.push_back(ev);
                m_data  = ev.data;
                m_break = ev.brk;
                m_ext   = 1'b0;
                m_brk   = 1'b0;
            end
        end
    endfunction

    task automatic wait_half(input bit glitch);
        if (glitch) begin
            repeat (HALF / 2) @(posedge clk);
            ps2Clk = ~ps2Clk;
            @(posedge clk);
            ps2Clk = ~ps2Clk;
            repeat (HALF / 2 - 1) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        if (nbits == 11) model_frame(b, !(bad_par || bad_stop));
        for (int i = 0; i < nbits; i++) begin
            ps2Dat = bits[i];
            wait_half(glitch);
            ps2Clk = 1'b0;
            wait_half(glitch);
            ps2Clk = 1'b1;
        end
        ps2Dat = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ps2Data"}, ps2Data, 0);
        check({tag, "_ps2Break"}, ps2Break, 0);
        check({tag, "_rawByte"}, rawByte, 0);
        check({tag, "_strobes"}, {rawValid, ps2Valid, frameErr}, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rawValid) begin
                check("raw_err_excl", frameErr, 0);
                if (raw_q.size() == 0) check("raw_unexpected", rawValid, 0);
                else begin
                    mon_b = raw_q.pop_front();
                    check("rawByte", rawByte, mon_b);
                end
            end
            if (ps2Valid) begin
                if (evt_q.size() == 0) check("evt_unexpected", ps2Valid, 0);
                else begin
                    mon_e = evt_q.pop_front();
                    check("ps2Data", ps2Data, mon_e.data);
                    check("ps2Break", ps2Break, mon_e.brk);
                end
            end
            if (frameErr) begin
                err_seen++;
                if (exp_err == 0) check("err_unexpected", frameErr, 0);
                else exp_err--;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] b;
        int r;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // Plain make, prefixed break, extended break, then flags must be clear again.
        send_frame(8'h2B, 0, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 0, 11);
        send_frame(8'h2B, 0, 0, 0, 11);
        send_frame(8'hE0, 0, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 0, 11);
        send_frame(8'h75, 0, 0, 0, 11);
        send_frame(8'h21, 0, 0, 0, 11);

        // Parity error on a byte after a prefix: discarded, flags cleared, outputs held.
        send_frame(8'hF0, 0, 0, 0, 11);
        send_frame(8'h1B, 1, 0, 0, 11);
        @(negedge clk);
        check("hold_after_err_data", ps2Data, m_data);
        check("hold_after_err_brk", ps2Break, m_break);
        send_frame(8'h1C, 0, 0, 0, 11);

        // A lone clock pulse with data high is not a start bit.
        base = err_seen;
        ps2Dat = 1'b1;
        repeat (HALF) @(posedge clk);
        ps2Clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2Clk = 1'b1;
        repeat (3 * HALF) @(posedge clk);
        check("ignored_start_no_err", err_seen, base);
        send_frame(8'h3A, 0, 0, 0, 11);

        // Abandoned frame after a break prefix: timeout ~100 idle cycles after last edge.
        send_frame(8'hE0, 0, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 0, 11);
        base = err_seen;
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_frame(8'h5A, 0, 0, 0, 5);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("timeout_not_early", err_seen, base);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("timeout_fired", err_seen, base + 1);
        check("hold_after_tmo_data", ps2Data, m_data);
        send_frame(8'h21, 0, 0, 0, 11);

        // Glitchy clock: every half period carries a one-cycle spike.
        send_frame(8'hA5, 0, 0, 1, 11);
        send_frame(8'hE0, 0, 0, 1, 11);
        send_frame(8'h6C, 0, 0, 1, 11);

        // Reset in the middle of a frame that follows a break prefix.
        send_frame(8'hF0, 0, 0, 0, 11);
        send_frame(8'h55, 0, 0, 0, 6);
        @(posedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midrst");
        @(posedge clk);
        rst = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_data = 16'h0000;
        m_break = 1'b0;
        repeat (10) @(posedge clk);
        send_frame(8'h21, 0, 0, 0, 11);

        // Random traffic: prefixes, ordinary codes, occasional bad parity/stop and glitches.
        for (int n = 0; n < 30; n++) begin
            b = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 9));
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            r = int'($urandom_range(0, 9));
            send_frame(b, r == 0, r == 1, $urandom_range(0, 3) == 0, 11);
        end

        repeat (50) @(posedge clk);
        @(negedge clk);
        check("raw_q_left", raw_q.size(), 0);
        check("evt_q_left", evt_q.size(), 0);
        check("err_pending", exp_err, 0);
        check("final_data", ps2Data, m_data);
        check("final_break", ps2Break, m_break);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
